// File: rtl/seq_divider_16bit_if.sv
// Start/done handshake bundle between a datapath controller and seq_divider_16bit.
// The controller uses the master modport, the divider the slave modport.
interface seq_divider_16bit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );
endinterface

// File: rtl/seq_divider_16bit.sv
// Multi-cycle restoring divider, one shift plus trial subtraction per clock.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (sign fix-up on the final edge).
module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst_n,
  seq_divider_16bit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE_R     = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] q_reg, q_nxt;
  logic [WIDTH-1:0] d_reg, d_nxt;
  logic [WIDTH:0]   r_reg, r_nxt;
  logic [WIDTH-1:0] quot, quot_nxt;
  logic [WIDTH-1:0] rem, rem_nxt;
  logic             dz, dz_nxt;
  logic             done_r, done_nxt;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH:0]   r_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic sign_q, sign_q_nxt;
  logic sign_r, sign_r_nxt;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? neg(x) : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x, input logic s);
    return s ? neg(x) : x;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      q_reg  <= '0;
      d_reg  <= '0;
      r_reg  <= '0;
      quot   <= '0;
      rem    <= '0;
      dz     <= 1'b0;
      done_r <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sign_q <= 1'b0;
      sign_r <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      q_reg  <= q_nxt;
      d_reg  <= d_nxt;
      r_reg  <= r_nxt;
      quot   <= quot_nxt;
      rem    <= rem_nxt;
      dz     <= dz_nxt;
      done_r <= done_nxt;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sign_q <= sign_q_nxt;
      sign_r <= sign_r_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    q_nxt     = q_reg;
    d_nxt     = d_reg;
    r_nxt     = r_reg;
    quot_nxt  = quot;
    rem_nxt   = rem;
    dz_nxt    = dz;
    done_nxt  = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sign_q_nxt = sign_q;
    sign_r_nxt = sign_r;
`endif
    // R never exceeds D, so its top bit is zero and the shift loses nothing
    r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    trial   = r_shift + ~{1'b0, d_reg} + ONE_R;
    if (!trial[WIDTH]) begin
      r_step = trial;
      q_step = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_step = r_shift;
      q_step = {q_reg[WIDTH-2:0], 1'b0};
    end

    case (state)
      IDLE: begin
        if (bus.start) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          q_nxt      = mag(bus.dividend);
          d_nxt      = mag(bus.divisor);
          sign_q_nxt = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          sign_r_nxt = bus.dividend[WIDTH-1];
`else
          q_nxt = bus.dividend;
          d_nxt = bus.divisor;
`endif
          r_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = (bus.divisor == '0) ? FINISH : CALC;
        end
      end
      CALC: begin
        q_nxt   = q_step;
        r_nxt   = r_step;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ITER) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          dz_nxt    = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          quot_nxt = apply_sign(q_step, sign_q);
          rem_nxt  = apply_sign(r_step[WIDTH-1:0], sign_r);
`else
          quot_nxt = q_step;
          rem_nxt  = r_step[WIDTH-1:0];
`endif
        end
      end
      FINISH: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
        dz_nxt    = 1'b1;
        quot_nxt  = '1;
        // Re-applying the dividend sign to its magnitude restores the original value
`ifdef SEQ_DIVIDER_SIGNED_EN
        rem_nxt = apply_sign(q_reg, sign_r);
`else
        rem_nxt = q_reg;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.quotient  = quot;
  assign bus.remainder = rem;
  assign bus.div_zero  = dz;

endmodule
